time_entry: RTL and testbench
=============================

TIME_ENTRY -- requirements
Module: time_entry

Interface
REQ-001 Parameter: REPEAT_DELAY_CYC, 50_000_000, hold cycles from first step to first auto-repeat step.
REQ-002 Parameter: REPEAT_RATE_CYC, 10_000_000, cycles between subsequent auto-repeat steps.
REQ-003 Port: clock  in  1  sole clock; all logic on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: prog  in  1  raw switch; 1 = edit mode, falling edge commits.
REQ-006 Port: up  in  1  raw switch; 1 = step increments, 0 = step decrements.
REQ-007 Port: increment  in  1  raw button; step the selected field.
REQ-008 Port: select  in  1  raw button; advance the selected field.
REQ-009 Port: init_state  out  19  committed countdown preset, binary hundredths of a second.
REQ-010 Port: load  out  1  one-cycle pulse; init_state holds the new value.
REQ-011 Port: editing  out  1  high while in EDIT.
REQ-012 Port: field_sel  out  2  0 = minutes, 1 = seconds, 2 = hundredths.
REQ-013 Port: bcd_digits  out  24  live edit value MM SS HH as six BCD nibbles, minutes-tens in [23:20].

Function
REQ-014 prog, up, increment and select SHALL each pass through a 2-flop synchronizer; all logic uses only synchronized levels.
REQ-015 Rising edge = synchronized level 1 while its previous-cycle copy is 0; a press sampled at edge N SHALL update field registers at edge N+3.
REQ-016 Fields SHALL be min 0-59, sec 0-59, hund 0-99, held as binary.
REQ-017 FSM states SHALL be IDLE, EDIT, COMMIT; IDLE->EDIT on prog=1; EDIT->COMMIT on prog=0; COMMIT->IDLE unconditionally after one cycle; COMMIT->EDIT never.
REQ-018 In IDLE and COMMIT, increment/select SHALL be ignored and the repeat counter held at 0.
REQ-019 In EDIT, an increment edge SHALL step the selected field by +1 (up=1) or -1 (up=0).
REQ-020 Stepping SHALL wrap within the field (59->0 and 0->59 for min/sec, 99->0 and 0->99 for hund) with no carry or borrow into other fields.
REQ-021 In EDIT, a select edge SHALL advance field_sel 0->1->2->0.
REQ-022 Increment and select edges in the same cycle: step applies to the field selected before advancing.
REQ-023 Auto-repeat: increment held high in EDIT SHALL produce one further step REPEAT_DELAY_CYC cycles after the edge-triggered step, then one every REPEAT_RATE_CYC cycles.
REQ-024 Releasing increment, a select edge, or leaving EDIT SHALL clear the repeat counter.
REQ-025 init_state SHALL be min*6000 + sec*100 + hund (max 359999, fits 19 bits).
REQ-026 That value SHALL be registered in the cycle the FSM is in COMMIT, so it changes at the same edge that raises load.
REQ-027 load SHALL be 1 exactly while the FSM is in COMMIT; init_state SHALL be held at all other times.
REQ-028 bcd_digits SHALL be registered and follow field changes with 1 cycle latency.
REQ-029 editing SHALL be 1 exactly in EDIT; field_sel is valid in all states.
REQ-030 up changing mid-hold SHALL take effect on the next repeat step.

Reset
REQ-031 reset SHALL override all other inputs in the cycle it is sampled.
REQ-032 Reset values: FSM IDLE; fields 0; field_sel 0; init_state 0; load 0; editing 0; bcd_digits 0; repeat counter 0; synchronizer flops 0.
REQ-033 Reset mid-EDIT SHALL discard edits and produce no load pulse.
REQ-034 After release with prog still high, the FSM SHALL enter EDIT once synchronized prog is 1; no commit occurs until a subsequent prog fall.

Verification (bench: REPEAT_DELAY_CYC=8, REPEAT_RATE_CYC=4)
REQ-035 Reset, prog=1, select x1, up=1, increment pulsed 45 times, prog=0 -> exactly one load pulse; init_state=4500; bcd_digits=0x004500.
REQ-036 Edit hund, up=0, single increment from 0 -> hund=99; min and sec unchanged; bcd_digits=0x000099.
REQ-037 Edit sec, increment held 20 cycles after edge -> steps at edge, +8, +12, +16, +20: sec=5.
REQ-038 Increment and select rise in same cycle with field_sel=0 -> min +1; field_sel=1.
REQ-039 Edit min to 3, assert reset for 1 cycle while prog=1 -> no load; fields 0; editing=1 again 3 cycles after reset falls.
REQ-040 prog=0 throughout, 10 increment pulses -> fields unchanged; load never asserted; init_state=0.

Source files
------------

// File: rtl/time_entry.sv
// Countdown preset entry: three wrapping MM:SS:HH fields edited with debounced-free
// synchronized switches, with hold-to-repeat stepping and a one-cycle commit pulse.
module time_entry #(
  parameter int REPEAT_DELAY_CYC = 50_000_000,
  parameter int REPEAT_RATE_CYC  = 10_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        prog,
  input  logic        up,
  input  logic        increment,
  input  logic        select,
  output logic [18:0] init_state,
  output logic        load,
  output logic        editing,
  output logic [1:0]  field_sel,
  output logic [23:0] bcd_digits
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Bit positions inside the synchronizer vectors.
  localparam int B_PROG = 3;
  localparam int B_UP   = 2;
  localparam int B_INC  = 1;
  localparam int B_SEL  = 0;

  // The repeat counter restarts at a reload value so a single threshold serves both
  // the initial delay and the steady rate; this assumes the rate is not longer than the delay.
  localparam int CW = $clog2(REPEAT_DELAY_CYC + 1);
  localparam logic [CW-1:0] REP_DELAY_C  = CW'(REPEAT_DELAY_CYC);
  localparam logic [CW-1:0] REP_RELOAD_C = CW'(REPEAT_DELAY_CYC - REPEAT_RATE_CYC + 32'sd1);
  localparam logic [CW-1:0] REP_ONE_C    = CW'(32'sd1);
  localparam logic [CW-1:0] REP_ZERO_C   = CW'(32'sd0);

  logic [3:0]    sync1_r;
  logic [3:0]    sync2_r;
  logic          inc_prev_r;
  logic          sel_prev_r;
  logic          inc_rise_r;
  logic          sel_rise_r;
  state_t        state_r;
  state_t        state_next_s;
  logic [6:0]    min_r;
  logic [6:0]    sec_r;
  logic [6:0]    hund_r;
  logic [6:0]    min_next_s;
  logic [6:0]    sec_next_s;
  logic [6:0]    hund_next_s;
  logic [1:0]    field_sel_r;
  logic [1:0]    field_sel_next_s;
  logic [CW-1:0] rep_cnt_r;
  logic [CW-1:0] rep_cnt_next_s;
  logic          in_edit_s;
  logic          held_s;
  logic          fire_s;
  logic          step_s;
  logic [18:0]   init_state_r;
  logic          load_r;
  logic          editing_r;
  logic [23:0]   bcd_r;

  function automatic logic [6:0] step_field(input logic [6:0] value,
                                            input logic [6:0] max_value,
                                            input logic       dir_up);
    logic [6:0] result;
    if (dir_up) begin
      if (value >= max_value) result = 7'd0;
      else                    result = value + 7'd1;
    end else begin
      if (value == 7'd0) result = max_value;
      else               result = value - 7'd1;
    end
    return result;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] value);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = value;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  function automatic logic [18:0] to_hundredths(input logic [6:0] m,
                                                input logic [6:0] s,
                                                input logic [6:0] h);
    return ({12'd0, m} * 19'd6000) + ({12'd0, s} * 19'd100) + {12'd0, h};
  endfunction

  // The edge pulse is registered once more so that the level used for repeat
  // holding (inc_prev_r) lines up with the step it belongs to.
  assign in_edit_s = (state_r == ST_EDIT);
  assign held_s    = inc_prev_r;
  assign fire_s    = in_edit_s && held_s && (rep_cnt_r == REP_DELAY_C);
  assign step_s    = in_edit_s && (inc_rise_r || fire_s);

  // Mode sequencing: enter on prog high, commit for exactly one cycle on prog low.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:   state_next_s = sync2_r[B_PROG] ? ST_EDIT : ST_IDLE;
      ST_EDIT:   state_next_s = sync2_r[B_PROG] ? ST_EDIT : ST_COMMIT;
      ST_COMMIT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Field stepping, field selection and the hold-to-repeat counter.
  always_comb begin
    min_next_s       = min_r;
    sec_next_s       = sec_r;
    hund_next_s      = hund_r;
    field_sel_next_s = field_sel_r;
    rep_cnt_next_s   = rep_cnt_r;

    if (step_s) begin
      case (field_sel_r)
        2'd0:    min_next_s  = step_field(min_r, 7'd59, sync2_r[B_UP]);
        2'd1:    sec_next_s  = step_field(sec_r, 7'd59, sync2_r[B_UP]);
        2'd2:    hund_next_s = step_field(hund_r, 7'd99, sync2_r[B_UP]);
        default: min_next_s  = min_r;
      endcase
    end else begin
      min_next_s = min_r;
    end

    if (in_edit_s && sel_rise_r) begin
      case (field_sel_r)
        2'd0:    field_sel_next_s = 2'd1;
        2'd1:    field_sel_next_s = 2'd2;
        default: field_sel_next_s = 2'd0;
      endcase
    end else begin
      field_sel_next_s = field_sel_r;
    end

    if (!in_edit_s || !held_s || sel_rise_r) begin
      rep_cnt_next_s = REP_ZERO_C;
    end else if (inc_rise_r) begin
      rep_cnt_next_s = REP_ONE_C;
    end else if (fire_s) begin
      rep_cnt_next_s = REP_RELOAD_C;
    end else if (rep_cnt_r != REP_ZERO_C) begin
      rep_cnt_next_s = rep_cnt_r + REP_ONE_C;
    end else begin
      rep_cnt_next_s = rep_cnt_r;
    end
  end

  // All state: synchronizers, edge detectors, FSM, fields and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_r      <= 4'd0;
      sync2_r      <= 4'd0;
      inc_prev_r   <= 1'b0;
      sel_prev_r   <= 1'b0;
      inc_rise_r   <= 1'b0;
      sel_rise_r   <= 1'b0;
      state_r      <= ST_IDLE;
      min_r        <= 7'd0;
      sec_r        <= 7'd0;
      hund_r       <= 7'd0;
      field_sel_r  <= 2'd0;
      rep_cnt_r    <= REP_ZERO_C;
      init_state_r <= 19'd0;
      load_r       <= 1'b0;
      editing_r    <= 1'b0;
      bcd_r        <= 24'd0;
    end else begin
      sync1_r      <= {prog, up, increment, select};
      sync2_r      <= sync1_r;
      inc_prev_r   <= sync2_r[B_INC];
      sel_prev_r   <= sync2_r[B_SEL];
      inc_rise_r   <= sync2_r[B_INC] & ~inc_prev_r;
      sel_rise_r   <= sync2_r[B_SEL] & ~sel_prev_r;
      state_r      <= state_next_s;
      min_r        <= min_next_s;
      sec_r        <= sec_next_s;
      hund_r       <= hund_next_s;
      field_sel_r  <= field_sel_next_s;
      rep_cnt_r    <= rep_cnt_next_s;
      load_r       <= (state_next_s == ST_COMMIT);
      editing_r    <= (state_next_s == ST_EDIT);
      bcd_r        <= {to_bcd(min_r), to_bcd(sec_r), to_bcd(hund_r)};
      // Capture from the next field values so a step landing on the commit edge is kept.
      if (state_next_s == ST_COMMIT) begin
        init_state_r <= to_hundredths(min_next_s, sec_next_s, hund_next_s);
      end else begin
        init_state_r <= init_state_r;
      end
    end
  end

  assign init_state = init_state_r;
  assign load       = load_r;
  assign editing    = editing_r;
  assign field_sel  = field_sel_r;
  assign bcd_digits = bcd_r;

endmodule

// File: tb/tb_time_entry.sv
// Directed bench for time_entry with short repeat timing (delay 8, rate 4).
module tb_time_entry;

  logic        clock = 1'b0;
  logic        reset;
  logic        prog;
  logic        up;
  logic        increment;
  logic        select;
  logic [18:0] init_state;
  logic        load;
  logic        editing;
  logic [1:0]  field_sel;
  logic [23:0] bcd_digits;

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  int load_base;

  time_entry #(
    .REPEAT_DELAY_CYC(8),
    .REPEAT_RATE_CYC (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .prog      (prog),
    .up        (up),
    .increment (increment),
    .select    (select),
    .init_state(init_state),
    .load      (load),
    .editing   (editing),
    .field_sel (field_sel),
    .bcd_digits(bcd_digits)
  );

  always #5 clock = ~clock;

  // Count cycles with load high, sampled mid-cycle.
  always @(negedge clock) begin
    if (load === 1'b1) load_cnt <= load_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic press_inc();
    increment = 1'b1;
    tick(2);
    increment = 1'b0;
    tick(2);
  endtask

  task automatic press_sel();
    select = 1'b1;
    tick(2);
    select = 1'b0;
    tick(2);
  endtask

  task automatic enter_edit();
    prog = 1'b1;
    tick(4);
  endtask

  initial begin
    reset = 1'b1; prog = 1'b0; up = 1'b1; increment = 1'b0; select = 1'b0;
    tick(2);

    // Load 45 seconds and commit.
    do_reset();
    check_eq("rst_init", 32'(init_state), 32'd0);
    check_eq("rst_load", 32'(load), 32'd0);
    check_eq("rst_editing", 32'(editing), 32'd0);
    check_eq("rst_field_sel", 32'(field_sel), 32'd0);
    check_eq("rst_bcd", 32'(bcd_digits), 32'd0);
    prog = 1'b1;
    tick(2);
    check_eq("edit_not_yet", 32'(editing), 32'd0);
    tick(1);
    check_eq("edit_entered", 32'(editing), 32'd1);
    tick(1);
    press_sel();
    check_eq("sel_to_sec", 32'(field_sel), 32'd1);
    increment = 1'b1;
    tick(4);
    check_eq("step_latency_before", 32'(bcd_digits), 32'h000000);
    tick(1);
    check_eq("step_latency_after", 32'(bcd_digits), 32'h000100);
    increment = 1'b0;
    tick(2);
    for (int i = 0; i < 44; i++) press_inc();
    tick(2);
    check_eq("bcd_4500", 32'(bcd_digits), 32'h004500);
    load_base = load_cnt;
    prog = 1'b0;
    tick(2);
    check_eq("load_not_yet", 32'(load), 32'd0);
    tick(1);
    check_eq("load_high", 32'(load), 32'd1);
    check_eq("init_4500", 32'(init_state), 32'd4500);
    check_eq("editing_off", 32'(editing), 32'd0);
    tick(1);
    check_eq("load_one_cycle", 32'(load), 32'd0);
    check_eq("init_held", 32'(init_state), 32'd4500);
    tick(4);
    check_eq("load_count_1", 32'(load_cnt - load_base), 32'd1);

    // Wrap tests on hundredths and minutes.
    do_reset();
    enter_edit();
    press_sel();
    press_sel();
    check_eq("sel_to_hund", 32'(field_sel), 32'd2);
    up = 1'b0;
    press_inc();
    tick(2);
    check_eq("hund_wrap_down", 32'(bcd_digits), 32'h000099);
    up = 1'b1;
    press_inc();
    tick(2);
    check_eq("hund_wrap_up", 32'(bcd_digits), 32'h000000);
    up = 1'b0;
    press_inc();
    press_sel();
    check_eq("sel_wrap_to_min", 32'(field_sel), 32'd0);
    press_inc();
    tick(2);
    check_eq("min_wrap_down", 32'(bcd_digits), 32'h590099);
    prog = 1'b0;
    tick(3);
    check_eq("load_max", 32'(load), 32'd1);
    check_eq("init_354099", 32'(init_state), 32'd354099);
    tick(2);

    // Hold-to-repeat on seconds.
    up = 1'b1;
    do_reset();
    enter_edit();
    press_sel();
    increment = 1'b1;
    tick(12);
    check_eq("rep_before_first", 32'(bcd_digits), 32'h000100);
    tick(1);
    check_eq("rep_first", 32'(bcd_digits), 32'h000200);
    tick(3);
    check_eq("rep_before_second", 32'(bcd_digits), 32'h000200);
    tick(1);
    check_eq("rep_second", 32'(bcd_digits), 32'h000300);
    tick(5);
    increment = 1'b0;
    tick(8);
    check_eq("rep_total_5", 32'(bcd_digits), 32'h000500);
    tick(10);
    check_eq("rep_stopped", 32'(bcd_digits), 32'h000500);

    // Simultaneous increment and select edges.
    prog = 1'b0;
    do_reset();
    enter_edit();
    increment = 1'b1;
    select = 1'b1;
    tick(2);
    increment = 1'b0;
    select = 1'b0;
    tick(4);
    check_eq("same_cycle_sel", 32'(field_sel), 32'd1);
    check_eq("same_cycle_min", 32'(bcd_digits), 32'h010000);
    prog = 1'b0;
    tick(3);
    check_eq("init_6000", 32'(init_state), 32'd6000);

    // Reset mid-edit discards edits and re-enters edit with prog still high.
    do_reset();
    enter_edit();
    press_inc();
    press_inc();
    press_inc();
    tick(2);
    check_eq("min_3", 32'(bcd_digits), 32'h030000);
    load_base = load_cnt;
    do_reset();
    check_eq("midrst_editing", 32'(editing), 32'd0);
    check_eq("midrst_bcd", 32'(bcd_digits), 32'd0);
    check_eq("midrst_init", 32'(init_state), 32'd0);
    tick(2);
    check_eq("reedit_not_yet", 32'(editing), 32'd0);
    tick(1);
    check_eq("reedit_3cyc", 32'(editing), 32'd1);
    tick(3);
    check_eq("midrst_no_load", 32'(load_cnt - load_base), 32'd0);
    prog = 1'b0;
    tick(3);
    check_eq("commit_zero_load", 32'(load), 32'd1);
    check_eq("commit_zero_init", 32'(init_state), 32'd0);
    tick(2);

    // Inputs ignored outside edit.
    do_reset();
    load_base = load_cnt;
    for (int i = 0; i < 10; i++) press_inc();
    press_sel();
    tick(4);
    check_eq("idle_bcd", 32'(bcd_digits), 32'd0);
    check_eq("idle_init", 32'(init_state), 32'd0);
    check_eq("idle_no_load", 32'(load_cnt - load_base), 32'd0);
    check_eq("idle_editing", 32'(editing), 32'd0);
    check_eq("idle_field_sel", 32'(field_sel), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
